// File: rtl/fc_phase_sequencer.sv
// Phase sequencer for the 3-bit Forth core: drives the fetch/execute phase bit,
// gates core register updates, owns the program RAM port and counts retired instructions.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | core stopped; loader owns the RAM port; waits for run/step
// S_LOAD  | loader burst in progress; ends on an accepted ld_last word
// S_FETCH | first cycle of the fetch phase (regP=0)
// S_FWAIT | fetch phase stretched by WAIT_CYCLES for slow RAM
// S_EXEC  | first cycle of the execute phase (regP=1)
// S_EWAIT | execute phase stretched by WAIT_CYCLES
module fc_phase_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 3,
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              regP,
  output logic              cpu_en,
  output logic              running,
  output logic              load_done,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_FWAIT, S_EXEC, S_EWAIT
  } state_t;

  localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t           state_q;
  logic [3:0]       wait_cnt_q;
  logic             step_mode_q;
  logic             halt_pend_q;
  logic             load_done_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] instr_cnt_d;

  logic loader_side;
  logic exec_phase;
  logic phase_end;

  assign loader_side = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign exec_phase  = (state_q == S_EXEC) || (state_q == S_EWAIT);
  assign instr_cnt_d = instr_cnt_q + CNT_W'(1);

  // cpu_en marks the last cycle of a phase, so the core only ever sees whole phases.
  always_comb begin
    phase_end = 1'b0;
    case (state_q)
      S_FETCH, S_EXEC: phase_end = NO_WAIT;
      S_FWAIT, S_EWAIT: phase_end = (wait_cnt_q == 4'd1);
      default: phase_end = 1'b0;
    endcase
  end

  assign ld_ready  = loader_side;
  assign running   = !loader_side;
  assign regP      = exec_phase;
  assign cpu_en    = phase_end;
  assign load_done = load_done_q;
  assign instr_cnt = instr_cnt_q;

  always_comb begin
    if (loader_side) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
      mem_we    = ld_valid;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we & phase_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 4'd0;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
      load_done_q <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld_valid) begin
            load_done_q <= ld_last;
            if (!ld_last) state_q <= S_LOAD;
          end else if (step) begin
            step_mode_q <= 1'b1;
            state_q     <= S_FETCH;
          end else if (run) begin
            step_mode_q <= 1'b0;
            state_q     <= S_FETCH;
          end
        end
        S_LOAD: begin
          if (ld_valid && ld_last) begin
            load_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (NO_WAIT) begin
            state_q <= S_EXEC;
          end else begin
            wait_cnt_q <= WAIT_INIT;
            state_q    <= S_FWAIT;
          end
        end
        S_FWAIT: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (!NO_WAIT) begin
            wait_cnt_q <= WAIT_INIT;
            state_q    <= S_EWAIT;
          end
        end
        S_EWAIT: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase

      if (!loader_side && halt_req) halt_pend_q <= 1'b1;

      // Retire: a halt arriving on the very last execute cycle still stops here.
      if (exec_phase && phase_end) begin
        instr_cnt_q <= instr_cnt_d;
        if (halt_pend_q || halt_req || step_mode_q) begin
          state_q     <= S_IDLE;
          halt_pend_q <= 1'b0;
          step_mode_q <= 1'b0;
        end else begin
          state_q <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_phase_sequencer.sv
// Scoreboard bench for fc_phase_sequencer: one instance with no RAM wait states,
// one with WAIT_CYCLES=2 and a 4-bit instruction counter.
module tb_fc_phase_sequencer;

  typedef struct packed {
    logic        regp;
    logic        en;
    logic [15:0] cnt;
  } tr_t;

  typedef struct packed {
    logic [7:0] a;
    logic [2:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       run0 = 0, step0 = 0, halt0 = 0, ldv0 = 0, cpu_we0 = 0;
  logic       run2 = 0, step2 = 0, halt2 = 0, ldv2 = 0, cpu_we2 = 0;
  logic       ld_last = 0;
  logic [7:0] ld_addr = 0, cpu_addr = 0;
  logic [2:0] ld_data = 0, cpu_wdata = 0;

  logic        ld_ready0, mem_we0, regp0, cpu_en0, running0, load_done0;
  logic [7:0]  mem_addr0;
  logic [2:0]  mem_wdata0;
  logic [15:0] cnt0;
  logic        ld_ready2, mem_we2, regp2, cpu_en2, running2, load_done2;
  logic [7:0]  mem_addr2;
  logic [2:0]  mem_wdata2;
  logic [3:0]  cnt2;

  fc_phase_sequencer #(.ADDR_W(8), .DATA_W(3), .WAIT_CYCLES(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .step(step0), .halt_req(halt0),
    .ld_valid(ldv0), .ld_ready(ld_ready0), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .cpu_addr(cpu_addr), .cpu_we(cpu_we0), .cpu_wdata(cpu_wdata),
    .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .regP(regp0),
    .cpu_en(cpu_en0), .running(running0), .load_done(load_done0), .instr_cnt(cnt0)
  );

  fc_phase_sequencer #(.ADDR_W(8), .DATA_W(3), .WAIT_CYCLES(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2), .step(step2), .halt_req(halt2),
    .ld_valid(ldv2), .ld_ready(ld_ready2), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .cpu_addr(cpu_addr), .cpu_we(cpu_we2), .cpu_wdata(cpu_wdata),
    .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_wdata(mem_wdata2), .regP(regp2),
    .cpu_en(cpu_en2), .running(running2), .load_done(load_done2), .instr_cnt(cnt2)
  );

  int  checks = 0;
  int  errors = 0;
  tr_t tq0[$];
  tr_t tq2[$];
  wr_t wq0[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output %0h at %0t", name, act, $time);
  endtask

  // Monitors: every running cycle and every RAM write must match a queued expectation.
  always @(negedge clk) begin
    if (running0) begin
      if (tq0.size() == 0) unexpected("trace0", 32'({regp0, cpu_en0, cnt0}));
      else chk("trace0", 32'({regp0, cpu_en0, cnt0}), 32'(tq0.pop_front()));
    end else if (cpu_en0) begin
      unexpected("cpu_en0_idle", 32'(cpu_en0));
    end
    if (mem_we0) begin
      if (wq0.size() == 0) unexpected("write0", 32'({mem_addr0, mem_wdata0}));
      else chk("write0", 32'({mem_addr0, mem_wdata0}), 32'(wq0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (running2) begin
      if (tq2.size() == 0) unexpected("trace2", 32'({regp2, cpu_en2, cnt2}));
      else chk("trace2", 32'({regp2, cpu_en2, 12'd0, cnt2}), 32'(tq2.pop_front()));
    end else if (cpu_en2) begin
      unexpected("cpu_en2_idle", 32'(cpu_en2));
    end
    if (mem_we2) unexpected("write2", 32'({mem_addr2, mem_wdata2}));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tr(input bit to2, input bit rp, input bit en, input int cnt);
    tr_t t;
    t.regp = rp;
    t.en   = en;
    t.cnt  = 16'(cnt);
    if (to2) tq2.push_back(t);
    else tq0.push_back(t);
  endtask

  // No wait states: fetch and execute are one cycle each, cpu_en always high.
  task automatic push_run0(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      push_tr(1'b0, 1'b0, 1'b1, start + i);
      push_tr(1'b0, 1'b1, 1'b1, start + i);
    end
  endtask

  // Two wait states: three cycles per phase, cpu_en only on the third; 4-bit counter.
  task automatic push_run2(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 6; k++)
        push_tr(1'b1, (k >= 3), (k == 2) || (k == 5), (start + i) % 16);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [2:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wq0.push_back(w);
  endtask

  logic [2:0] ld_vals[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ld_vals = '{3'b001, 3'b010, 3'b100, 3'b111};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_running", 32'(running0), 32'd0);
    chk("rst_regp", 32'(regp0), 32'd0);
    chk("rst_cpu_en", 32'(cpu_en0), 32'd0);
    chk("rst_load_done", 32'(load_done0), 32'd0);
    chk("rst_instr_cnt", 32'(cnt0), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready0), 32'd1);
    rst_n = 1'b1;
    tick();

    // Program load of four words
    for (int i = 0; i < 4; i++) push_wr(8'(i), ld_vals[i]);
    for (int i = 0; i < 4; i++) begin
      ldv0    = 1'b1;
      ld_addr = 8'(i);
      ld_data = ld_vals[i];
      ld_last = (i == 3);
      tick();
    end
    ldv0 = 1'b0;
    ld_last = 1'b0;
    chk("load_done", 32'(load_done0), 32'd1);
    chk("load_ld_ready", 32'(ld_ready0), 32'd1);
    chk("load_idle", 32'(running0), 32'd0);
    chk("load_writes_seen", 32'(wq0.size()), 32'd0);

    // Free run, halt requested in the fetch of the sixth instruction
    push_run0(6, 0);
    run0 = 1'b1;
    tick();
    run0 = 1'b0;
    repeat (10) tick();
    halt0 = 1'b1;
    tick();
    halt0 = 1'b0;
    tick();
    chk("run_stopped", 32'(running0), 32'd0);
    chk("run_cnt", 32'(cnt0), 32'd6);

    // step and run together: step wins, one instruction only
    push_run0(1, 6);
    step0 = 1'b1;
    run0  = 1'b1;
    tick();
    step0 = 1'b0;
    run0  = 1'b0;
    repeat (2) tick();
    chk("step_stopped", 32'(running0), 32'd0);
    chk("step_cnt", 32'(cnt0), 32'd7);

    // Loader locked out while running; core write in EXEC reaches the RAM
    push_run0(2, 7);
    push_wr(8'h3C, 3'b101);
    cpu_addr = 8'h3C;
    run0 = 1'b1;
    tick();
    run0    = 1'b0;
    ldv0    = 1'b1;
    ld_addr = 8'h05;
    ld_data = 3'b110;
    @(negedge clk);
    chk("busy_ld_ready", 32'(ld_ready0), 32'd0);
    chk("busy_mem_addr", 32'(mem_addr0), 32'h3C);
    @(posedge clk);
    #1;
    cpu_we0   = 1'b1;
    cpu_wdata = 3'b101;
    tick();
    cpu_we0 = 1'b0;
    halt0   = 1'b1;
    tick();
    halt0 = 1'b0;
    ldv0  = 1'b0;
    tick();
    chk("busy_stopped", 32'(running0), 32'd0);
    chk("busy_cnt", 32'(cnt0), 32'd9);
    chk("busy_writes_seen", 32'(wq0.size()), 32'd0);

    // Asynchronous reset in the middle of EXEC
    push_run0(1, 9);
    void'(tq0.pop_back());
    run0 = 1'b1;
    tick();
    run0 = 1'b0;
    tick();
    #2;
    chk("mid_exec_regp", 32'(regp0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_regp", 32'(regp0), 32'd0);
    chk("async_cpu_en", 32'(cpu_en0), 32'd0);
    chk("async_running", 32'(running0), 32'd0);
    chk("async_cnt", 32'(cnt0), 32'd0);
    chk("async_load_done", 32'(load_done0), 32'd0);
    chk("async_ld_ready", 32'(ld_ready0), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Halt at cycle 3 (fetch of the second instruction)
    push_run0(2, 0);
    run0 = 1'b1;
    tick();
    run0 = 1'b0;
    repeat (2) tick();
    halt0 = 1'b1;
    tick();
    halt0 = 1'b0;
    tick();
    chk("halt3_stopped", 32'(running0), 32'd0);
    chk("halt3_cnt", 32'(cnt0), 32'd2);

    // Two wait states, 17 instructions through a 4-bit counter wrap
    push_run2(17, 0);
    run2 = 1'b1;
    tick();
    run2 = 1'b0;
    repeat (96) tick();
    halt2 = 1'b1;
    tick();
    halt2 = 1'b0;
    repeat (8) tick();
    chk("wait_stopped", 32'(running2), 32'd0);
    chk("wait_cnt_wrap", 32'(cnt2), 32'd1);
    chk("trace0_drained", 32'(tq0.size()), 32'd0);
    chk("trace2_drained", 32'(tq2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
